// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-cycle 1-bit-per-cycle shift/rotate sequencer
module shift_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in_bit,
    input  logic [2:0]       amount,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out_bit,
    output logic             carry_out,
    output logic             zero_out
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] M_LOG = 2'b00;
    localparam logic [1:0] M_ARI = 2'b01;
    localparam logic [1:0] M_ROT = 2'b10;
    localparam logic [1:0] M_RTC = 2'b11;

    state_t           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic             wcarry_q, wcarry_d;
    logic             dir_q, dir_d;
    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             cout_q, cout_d;
    logic             zero_q, zero_d;

    logic [WIDTH-1:0] step_r;
    logic             step_c;

    // One 1-bit step of the working register; carry always takes the bit shifted out.
    always_comb begin
        step_r = work_q;
        step_c = 1'b0;
        if (dir_q) begin
            step_c = work_q[WIDTH-1];
            case (mode_q)
                M_ROT:   step_r = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
                M_RTC:   step_r = {work_q[WIDTH-2:0], wcarry_q};
                default: step_r = {work_q[WIDTH-2:0], 1'b0};
            endcase
        end else begin
            step_c = work_q[0];
            case (mode_q)
                M_LOG:   step_r = {1'b0, work_q[WIDTH-1:1]};
                M_ARI:   step_r = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
                M_ROT:   step_r = {work_q[0], work_q[WIDTH-1:1]};
                default: step_r = {wcarry_q, work_q[WIDTH-1:1]};
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        wcarry_d = wcarry_q;
        dir_d    = dir_q;
        mode_d   = mode_q;
        out_d    = out_q;
        cout_d   = cout_q;
        zero_d   = zero_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    work_d   = in_bit;
                    wcarry_d = carry_in;
                    dir_d    = dir;
                    mode_d   = mode;
                    cnt_d    = amount;
                    if (amount == 3'd0) begin
                        state_d = S_DONE;
                        out_d   = in_bit;
                        cout_d  = carry_in;
                        zero_d  = (in_bit == '0);
                    end else begin
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                work_d   = step_r;
                wcarry_d = step_c;
                cnt_d    = cnt_q - 3'd1;
                // Result registers are loaded on the final step so they are valid with done.
                if (cnt_q == 3'd1) begin
                    state_d = S_DONE;
                    out_d   = step_r;
                    cout_d  = step_c;
                    zero_d  = (step_r == '0);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 3'd0;
            work_q   <= '0;
            wcarry_q <= 1'b0;
            dir_q    <= 1'b0;
            mode_q   <= 2'b00;
            out_q    <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            wcarry_q <= wcarry_d;
            dir_q    <= dir_d;
            mode_q   <= mode_d;
            out_q    <= out_d;
            cout_q   <= cout_d;
            zero_q   <= zero_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign out_bit   = out_q;
    assign carry_out = cout_q;
    assign zero_out  = zero_q;

endmodule
